// File: rtl/xoro_pkg.sv
// Shared types and constants for the xoroshiro128+ word FIFO.
//   WORD_W / RND_W : FIFO word width and PRNG sample width
//   xoro_state_e   : splitter FSM states
//   xoro_clog2     : ceil(log2(n)), never less than 1 (safe as a vector width)
package xoro_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned RND_W  = 64;

    typedef enum logic [1:0] {
        StWarm,
        StLoad,
        StHi
    } xoro_state_e;

    function automatic int unsigned xoro_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/xoro_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, resn      : clock and asynchronous active-low reset (clears storage too)
//   push, wdata    : write strobe and data; caller guarantees !full or simultaneous pop
//   pop            : read strobe; caller guarantees !empty
//   rdata          : head word, zero while empty
//   count          : registered occupancy
//   full, empty    : occupancy flags
module xoro_sync_fifo
    import xoro_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = xoro_clog2(DEPTH),
    localparam int unsigned CW = xoro_clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        count = count_q;
        rdata = empty ? '0 : mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/xoro_word_fifo.sv
// Captures free-running xoroshiro128+ samples, splits each into two 32-bit
// words (low half first) and serves them through a valid/ready stream.
// The first WARMUP samples after reset are discarded. Samples arriving while
// the FIFO cannot accept a word are skipped, never queued.
//   clk, resn  : clock and asynchronous active-low reset
//   rnd_in     : 64-bit PRNG output, new value every cycle
//   out_data   : head word (zero while empty)
//   out_valid  : FIFO non-empty
//   out_ready  : consumer takes out_data this cycle
//   level      : registered FIFO occupancy
// Build option: XORO_HI_ONLY_EN -- keep only rnd_in[63:32] of each sample,
// one word per sample, no hold register or HI state.
module xoro_word_fifo
    import xoro_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WARMUP = 2,
    localparam int unsigned LW = xoro_clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resn,
    input  logic [RND_W-1:0]  rnd_in,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LW-1:0]     level
);

    localparam int unsigned WW = xoro_clog2(WARMUP + 1);
    localparam logic [WW-1:0] WarmLast = WW'(WARMUP - 1);
    localparam xoro_state_e StReset = (WARMUP == 0) ? StLoad : StWarm;

    xoro_state_e       state_q;
    logic [WW-1:0]     warm_cnt_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              wr_en;
    logic              push;
    logic [WORD_W-1:0] wdata;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // A pop this cycle frees the slot the push needs, so full does not block.
    assign wr_en     = !fifo_full || pop;

`ifdef XORO_HI_ONLY_EN
    assign push  = (state_q == StLoad) && wr_en;
    assign wdata = rnd_in[63:32];

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q    <= StReset;
            warm_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StWarm: begin
                    if (warm_cnt_q == WarmLast) begin
                        state_q <= StLoad;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + WW'(1);
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end
`else
    logic [WORD_W-1:0] hold_q;

    assign push  = ((state_q == StLoad) || (state_q == StHi)) && wr_en;
    assign wdata = (state_q == StHi) ? hold_q : rnd_in[31:0];

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q    <= StReset;
            warm_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            unique case (state_q)
                StWarm: begin
                    if (warm_cnt_q == WarmLast) begin
                        state_q <= StLoad;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + WW'(1);
                    end
                end
                StLoad: begin
                    if (wr_en) begin
                        hold_q  <= rnd_in[63:32];
                        state_q <= StHi;
                    end
                end
                StHi: begin
                    if (wr_en) begin
                        state_q <= StLoad;
                    end
                end
                default: state_q <= StReset;
            endcase
        end
    end
`endif

    xoro_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .resn  (resn),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (out_data),
        .count (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
